branch_resolve_unit: RTL

//  Consumes the C/V/Z/N flags the EX-stage arithmetic unit produces for a subtract (A=rs1, B=rs2, AS=1).

---
 rtl/branch_resolve_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I branch/JAL/JALR outcomes from EX-stage subtract flags and squashes wrong-path slots.
// Optional performance counters are enabled with BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int SHADOW_LEN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            flag_c,
    input  logic            flag_v,
    input  logic            flag_z,
    input  logic            flag_n,
    output logic            out_valid,
    output logic            taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] link_pc,
    output logic            illegal_br,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts,
`endif
    output logic            squash
);

    typedef enum logic {
        RUN,
        SHADOW
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [2:0]      SHADOW_LD = 3'(SHADOW_LEN);

    state_t          state;
    state_t          state_next;
    logic [2:0]      count;
    logic [2:0]      count_next;

    logic            accept;
    logic            cond;
    logic            taken_d;
    logic            redirect_d;
    logic            illegal_d;
    logic [XLEN-1:0] link_d;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] next_pc_d;

    assign squash = (state == SHADOW) && in_valid;
    assign accept = (state == RUN) && in_valid;

    // Branch condition from the rs1-rs2 flags; C=1 means no borrow (rs1 >= rs2 unsigned)
    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000:  cond = flag_z;
            3'b001:  cond = ~flag_z;
            3'b100:  cond = flag_n ^ flag_v;
            3'b101:  cond = ~(flag_n ^ flag_v);
            3'b110:  cond = ~flag_c;
            3'b111:  cond = flag_c;
            default: cond = 1'b0;
        endcase
    end

    // Direction, mispredict and correct next PC, with jalr > jal > branch priority
    always_comb begin
        link_d     = pc + PC_STEP;
        br_target  = pc + imm;
        jalr_sum   = rs1 + imm;
        taken_d    = 1'b0;
        redirect_d = 1'b0;
        illegal_d  = 1'b0;
        next_pc_d  = link_d;
        if (is_jalr) begin
            taken_d    = 1'b1;
            redirect_d = 1'b1;
            next_pc_d  = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            taken_d    = 1'b1;
            redirect_d = ~pred_taken;
            next_pc_d  = br_target;
        end else if (is_branch) begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
                illegal_d  = 1'b1;
                redirect_d = pred_taken;
            end else begin
                taken_d    = cond;
                redirect_d = cond ^ pred_taken;
                next_pc_d  = cond ? br_target : link_d;
            end
        end
    end

    // Shadow counter: runs down every cycle in SHADOW regardless of in_valid
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            RUN: begin
                if (accept && redirect_d) begin
                    state_next = SHADOW;
                    count_next = SHADOW_LD;
                end
            end
            SHADOW: begin
                count_next = count - 3'd1;
                if (count == 3'd1) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                count_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            count <= 3'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Results live for exactly one cycle and are zeroed whenever nothing was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            redirect    <= 1'b0;
            illegal_br  <= 1'b0;
            redirect_pc <= '0;
            link_pc     <= '0;
        end else begin
            out_valid   <= accept;
            taken       <= accept && taken_d;
            redirect    <= accept && redirect_d;
            illegal_br  <= accept && illegal_d;
            redirect_pc <= accept ? next_pc_d : '0;
            link_pc     <= accept ? link_d : '0;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else begin
            if (accept && is_branch && perf_branches != 32'hFFFF_FFFF) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (accept && redirect_d && perf_mispredicts != 32'hFFFF_FFFF) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
